// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared readout types, default widths and the reference quantizer
package readout_pkg;

    localparam int DEF_N_SAMPLES = 16;
    localparam int DEF_SAMPLE_W  = 16;
    localparam int DEF_SHIFT     = 8;
    localparam int DEF_Q_BITS    = 2;

    typedef logic signed [DEF_Q_BITS-1:0] quant_t;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    localparam logic signed [DEF_SAMPLE_W-1:0] Q_MAX_S = DEF_SAMPLE_W'((1 <<< (DEF_Q_BITS-1)) - 1);
    localparam logic signed [DEF_SAMPLE_W-1:0] Q_MIN_S = DEF_SAMPLE_W'(-(1 <<< (DEF_Q_BITS-1)));

    // Same arithmetic as readout_quantizer at the default widths; exported to the software model.
    function automatic quant_t quantize(input logic signed [DEF_SAMPLE_W-1:0] sample,
                                        input int unsigned shift);
        logic signed [DEF_SAMPLE_W-1:0] v;
        v = sample >>> shift;
        if (v > Q_MAX_S)
            return Q_MAX_S[DEF_Q_BITS-1:0];
        else if (v < Q_MIN_S)
            return Q_MIN_S[DEF_Q_BITS-1:0];
        else
            return v[DEF_Q_BITS-1:0];
    endfunction

endpackage

// File: rtl/readout_quantizer.sv
// rtl/readout_quantizer.sv - arithmetic shift then saturating clamp of one signed sample
module readout_quantizer
    import readout_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int Q_BITS   = DEF_Q_BITS,
    parameter int SHIFT    = DEF_SHIFT
) (
    input  logic [SAMPLE_W-1:0] sample,
    output logic [Q_BITS-1:0]   quant
);

    localparam logic signed [SAMPLE_W-1:0] QMAX = SAMPLE_W'((1 <<< (Q_BITS-1)) - 1);
    localparam logic signed [SAMPLE_W-1:0] QMIN = SAMPLE_W'(-(1 <<< (Q_BITS-1)));

    logic signed [SAMPLE_W-1:0] shifted;

    // Truncating shift: rounds toward minus infinity, never to nearest.
    assign shifted = $signed(sample) >>> SHIFT;

    always_comb begin
        quant = shifted[Q_BITS-1:0];
        if (shifted > QMAX)
            quant = QMAX[Q_BITS-1:0];
        else if (shifted < QMIN)
            quant = QMIN[Q_BITS-1:0];
    end

endmodule

// File: rtl/layer0_input_framer.sv
// rtl/layer0_input_framer.sv - ping-pong framer packing quantized I/Q shots into layer0 feature vectors
module layer0_input_framer
    import readout_pkg::*;
#(
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int SHIFT     = DEF_SHIFT,
    parameter int Q_BITS    = DEF_Q_BITS,
    localparam int OUT_W    = 2*N_SAMPLES*Q_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_i,
    input  logic [SAMPLE_W-1:0] s_q,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [OUT_W-1:0]    m_data,
    output logic                m_err
);

    localparam int IDX_W  = $clog2(N_SAMPLES+1);
    localparam int BEAT_W = 2*Q_BITS;

    logic [Q_BITS-1:0] q_i;
    logic [Q_BITS-1:0] q_q;

    readout_quantizer #(
        .SAMPLE_W (SAMPLE_W),
        .Q_BITS   (Q_BITS),
        .SHIFT    (SHIFT)
    ) u_quant_i (
        .sample (s_i),
        .quant  (q_i)
    );

    readout_quantizer #(
        .SAMPLE_W (SAMPLE_W),
        .Q_BITS   (Q_BITS),
        .SHIFT    (SHIFT)
    ) u_quant_q (
        .sample (s_q),
        .quant  (q_q)
    );

    bank_state_t              bank_state      [2];
    bank_state_t              bank_state_next [2];
    logic [1:0][OUT_W-1:0]    bank_data;
    logic [1:0]               bank_err;
    logic                     fill_sel;
    logic                     out_sel;
    logic [IDX_W-1:0]         wr_idx;
    logic                     beat;
    logic                     done;
    logic                     handshake;

    assign s_ready   = (bank_state[fill_sel] != BANK_FULL);
    assign beat      = s_valid & s_ready;
    assign done      = beat & s_last;

    // Outputs are pure selects of bank registers, so no input can reach them within a cycle.
    assign m_valid   = (bank_state[out_sel] == BANK_FULL);
    assign m_data    = bank_data[out_sel];
    assign m_err     = bank_err[out_sel];
    assign handshake = m_valid & m_ready;

    // The fill bank is never FULL while accepting, so release and fill never hit the same bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_state_next[b] = bank_state[b];
            if (handshake && out_sel == 1'(b))
                bank_state_next[b] = BANK_EMPTY;
            if (beat && fill_sel == 1'(b))
                bank_state_next[b] = s_last ? BANK_FULL : BANK_FILLING;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
        end else begin
            bank_state[0] <= bank_state_next[0];
            bank_state[1] <= bank_state_next[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_data <= '0;
            bank_err  <= '0;
            fill_sel  <= 1'b0;
            out_sel   <= 1'b0;
            wr_idx    <= '0;
        end else begin
            if (handshake)
                out_sel <= ~out_sel;

            // wr_idx saturates at N_SAMPLES, marking overflow beats that are accepted and dropped.
            if (done) begin
                fill_sel           <= ~fill_sel;
                wr_idx             <= '0;
                bank_err[fill_sel] <= (wr_idx != IDX_W'(N_SAMPLES-1));
            end else if (beat && wr_idx != IDX_W'(N_SAMPLES)) begin
                wr_idx <= wr_idx + 1'b1;
            end

            // The first beat of a shot also clears the rest of the bank, so short shots read as zero.
            if (beat) begin
                for (int n = 0; n < N_SAMPLES; n++) begin
                    if (wr_idx == IDX_W'(n))
                        bank_data[fill_sel][n*BEAT_W +: BEAT_W] <= {q_q, q_i};
                    else if (wr_idx == '0)
                        bank_data[fill_sel][n*BEAT_W +: BEAT_W] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer0_input_framer.sv
// tb/tb_layer0_input_framer.sv - self-checking bench for layer0_input_framer
module tb_layer0_input_framer;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_i;
    logic [15:0] s_q;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] got_data[$];
    logic        got_err[$];

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [1:0]  exp_i;
        logic [1:0]  exp_q;
    } vec_t;

    vec_t tbl[16];

    layer0_input_framer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_i     (s_i),
        .s_q     (s_q),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_err   (m_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after posedge, so values at negedge are what the next posedge sees.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            got_data.push_back(m_data);
            got_err.push_back(m_err);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [15:0] i, input logic [15:0] q, input logic last);
        int waits;
        waits   = 0;
        s_valid = 1'b1;
        s_i     = i;
        s_q     = q;
        s_last  = last;
        while (!s_ready && waits < 300) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=s_ready_low required=s_ready_high");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_shot(input int n_beats, input logic [15:0] i, input logic [15:0] q);
        for (int b = 1; b <= n_beats; b++)
            send_beat(i, q, b == n_beats);
    endtask

    task automatic pop_vec(input string name, input logic [63:0] exp_data, input logic exp_err);
        logic [63:0] d;
        logic        e;
        checks++;
        if (got_data.size() == 0) begin
            errors++;
            $display("FAIL %s_present actual=none required=vector", name);
        end else begin
            d = got_data.pop_front();
            e = got_err.pop_front();
            chk({name, "_data"}, d, exp_data);
            chk({name, "_err"}, 64'(e), 64'(exp_err));
        end
    endtask

    initial begin
        logic [63:0] v;
        logic        e;

        tbl[0]  = '{16'h0300, 16'hFD00, 2'b01, 2'b10};
        tbl[1]  = '{16'h00FF, 16'hFFFF, 2'b00, 2'b11};
        tbl[2]  = '{16'h7FFF, 16'h8000, 2'b01, 2'b10};
        tbl[3]  = '{16'h0100, 16'hFF00, 2'b01, 2'b11};
        tbl[4]  = '{16'h01FF, 16'hFE00, 2'b01, 2'b10};
        tbl[5]  = '{16'h0200, 16'hFEFF, 2'b01, 2'b10};
        tbl[6]  = '{16'h0000, 16'hFF01, 2'b00, 2'b11};
        tbl[7]  = '{16'h0080, 16'hFF80, 2'b00, 2'b11};
        tbl[8]  = '{16'h00FF, 16'h0100, 2'b00, 2'b01};
        tbl[9]  = '{16'h4000, 16'hC000, 2'b01, 2'b10};
        tbl[10] = '{16'hFFFF, 16'h0000, 2'b11, 2'b00};
        tbl[11] = '{16'h0101, 16'hFEFF, 2'b01, 2'b10};
        tbl[12] = '{16'h8001, 16'h7F00, 2'b10, 2'b01};
        tbl[13] = '{16'h0180, 16'hFE80, 2'b01, 2'b10};
        tbl[14] = '{16'h0000, 16'h0000, 2'b00, 2'b00};
        tbl[15] = '{16'hFF00, 16'h0100, 2'b11, 2'b01};

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_i     = '0;
        s_q     = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        idle(3);
        rst_n = 1'b1;

        chk("reset_m_valid", 64'(m_valid), 64'd0);
        chk("reset_m_data", m_data, 64'd0);
        chk("reset_m_err", 64'(m_err), 64'd0);
        chk("reset_s_ready", 64'(s_ready), 64'd1);

        // Full shot, presented the cycle after s_last
        m_ready = 1'b1;
        send_shot(16, 16'h0300, 16'hFD00);
        chk("t1_latency_m_valid", 64'(m_valid), 64'd1);
        chk("t1_direct_data", m_data, 64'h9999_9999_9999_9999);
        idle(3);
        pop_vec("t1", 64'h9999_9999_9999_9999, 1'b0);

        // Quantizer table, one sample per record
        for (int n = 0; n < 16; n++)
            send_beat(tbl[n].i, tbl[n].q, n == 15);
        idle(3);
        checks++;
        if (got_data.size() == 0) begin
            errors++;
            $display("FAIL tbl_present actual=none required=vector");
        end else begin
            v = got_data.pop_front();
            e = got_err.pop_front();
            chk("tbl_err", 64'(e), 64'd0);
            for (int n = 0; n < 16; n++) begin
                chk($sformatf("tbl%0d_i", n), 64'(v[4*n +: 2]), 64'(tbl[n].exp_i));
                chk($sformatf("tbl%0d_q", n), 64'(v[4*n+2 +: 2]), 64'(tbl[n].exp_q));
            end
        end

        // Short shot, then a normal one
        send_shot(10, 16'h0300, 16'hFD00);
        idle(3);
        pop_vec("short", 64'h0000_0099_9999_9999, 1'b1);
        send_shot(16, 16'h0300, 16'hFD00);
        idle(3);
        pop_vec("after_short", 64'h9999_9999_9999_9999, 1'b0);

        // Long shot: beats 17..20 carry a different pattern and must be dropped
        for (int b = 1; b <= 20; b++) begin
            if (b <= 16)
                send_beat(16'h0300, 16'hFD00, 1'b0);
            else
                send_beat(16'hFD00, 16'h0300, b == 20);
        end
        idle(3);
        pop_vec("long", 64'h9999_9999_9999_9999, 1'b1);
        chk("long_one_vector", 64'(got_data.size()), 64'd0);

        // Backpressure across three shots
        m_ready = 1'b0;
        send_shot(16, 16'h0100, 16'h0000);
        send_shot(16, 16'h0000, 16'hFF00);
        chk("bp_s_ready_low", 64'(s_ready), 64'd0);
        chk("bp_m_valid", 64'(m_valid), 64'd1);
        chk("bp_oldest_first", m_data, 64'h1111_1111_1111_1111);
        fork
            send_shot(16, 16'hFE00, 16'h7FFF);
            begin
                idle(5);
                chk("bp_still_stalled", 64'(s_ready), 64'd0);
                m_ready = 1'b1;
            end
        join
        idle(4);
        chk("bp_count", 64'(got_data.size()), 64'd3);
        pop_vec("bp_a", 64'h1111_1111_1111_1111, 1'b0);
        pop_vec("bp_b", 64'hCCCC_CCCC_CCCC_CCCC, 1'b0);
        pop_vec("bp_c", 64'h6666_6666_6666_6666, 1'b0);

        // Reset mid-shot with one bank FULL
        m_ready = 1'b0;
        send_shot(16, 16'h0300, 16'hFD00);
        for (int b = 1; b <= 6; b++)
            send_beat(16'h0100, 16'h0100, 1'b0);
        s_valid = 1'b1;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("rst_mid_m_valid", 64'(m_valid), 64'd0);
        chk("rst_mid_m_data", m_data, 64'd0);
        chk("rst_mid_m_err", 64'(m_err), 64'd0);
        chk("rst_mid_s_ready", 64'(s_ready), 64'd1);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        idle(10);
        chk("rst_no_stale", 64'(got_data.size()), 64'd0);
        send_shot(16, 16'h0300, 16'hFD00);
        idle(3);
        pop_vec("post_rst", 64'h9999_9999_9999_9999, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
